id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/riscv_pkg.sv | 41 ++++
 rtl/id_ex_reg.sv | 94 +++++++++
 tb/tb_id_ex_reg.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: default datapath width, the decoded
// control bundle carried down the pipe, the immediate-format selector used
// by the extender, and the bubble control word.
package riscv_pkg;

    localparam int DEFAULT_XLEN = 32;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } immsrc_e;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] resultsrc;
        logic       memwrite;
        logic       jump;
        logic       branch;
        logic [3:0] alucontrol;
        logic       alusrc;
        immsrc_e    immsrc;
    } ctrl_t;

    // A bubble must never write the register file or memory and never
    // redirect the PC; the remaining fields are zeroed as well so a bubble
    // is easy to spot on a waveform.
    localparam ctrl_t CTRL_NOP = '{
        regwrite:   1'b0,
        resultsrc:  2'b00,
        memwrite:   1'b0,
        jump:       1'b0,
        branch:     1'b0,
        alucontrol: 4'b0000,
        alusrc:     1'b0,
        immsrc:     IMM_I
    };

endpackage

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: a flat one-cycle register stage between decode
// and execute with flush (bubble), stall (hold) and load behaviour.
// Optional feature: define ID_EX_BUBBLE_CNT_EN to add a saturating 32-bit
// count of bubbles loaded into the stage (output bubble_cnt).
module id_ex_reg
    import riscv_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic            valid_d,
    input  ctrl_t           ctrl_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pcplus4_d,
    input  logic [XLEN-1:0] rd1_d,
    input  logic [XLEN-1:0] rd2_d,
    input  logic [XLEN-1:0] immext_d,
    input  logic [4:0]      rs1_d,
    input  logic [4:0]      rs2_d,
    input  logic [4:0]      rd_d,
    output logic            valid_e,
    output ctrl_t           ctrl_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pcplus4_e,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] immext_e,
    output logic [4:0]      rs1_e,
    output logic [4:0]      rs2_e,
    output logic [4:0]      rd_e
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [31:0]     bubble_cnt
`endif
);

    // A bubble enters on flush (which beats stall) or on an unstalled edge
    // whose decode slot is empty.
    logic take_bubble;
    assign take_bubble = flush_e | (~stall_e & ~valid_d);

    // Stage register: bubble, hold on stall, otherwise capture decode as-is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_e   <= 1'b0;
            ctrl_e    <= CTRL_NOP;
            pc_e      <= '0;
            pcplus4_e <= '0;
            rd1_e     <= '0;
            rd2_e     <= '0;
            immext_e  <= '0;
            rs1_e     <= '0;
            rs2_e     <= '0;
            rd_e      <= '0;
        end else if (take_bubble) begin
            valid_e   <= 1'b0;
            ctrl_e    <= CTRL_NOP;
            pc_e      <= '0;
            pcplus4_e <= '0;
            rd1_e     <= '0;
            rd2_e     <= '0;
            immext_e  <= '0;
            rs1_e     <= '0;
            rs2_e     <= '0;
            rd_e      <= '0;
        end else if (!stall_e) begin
            valid_e   <= 1'b1;
            ctrl_e    <= ctrl_d;
            pc_e      <= pc_d;
            pcplus4_e <= pcplus4_d;
            rd1_e     <= rd1_d;
            rd2_e     <= rd2_d;
            immext_e  <= immext_d;
            rs1_e     <= rs1_d;
            rs2_e     <= rs2_d;
            rd_e      <= rd_d;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    // Count bubbles entering the stage, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (take_bubble && (bubble_cnt != 32'hFFFF_FFFF)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios followed by a random
// run, all compared against a behavioural model of the stage contents.
module tb_id_ex_reg;
    import riscv_pkg::*;

    localparam int XLEN = DEFAULT_XLEN;

    typedef struct {
        logic            valid;
        ctrl_t           ctrl;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] immext;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } stage_t;

    logic            clk;
    logic            rst_n;
    logic            stall_e;
    logic            flush_e;
    logic            valid_d;
    ctrl_t           ctrl_d;
    logic [XLEN-1:0] pc_d, pcplus4_d, rd1_d, rd2_d, immext_d;
    logic [4:0]      rs1_d, rs2_d, rd_d;
    logic            valid_e;
    ctrl_t           ctrl_e;
    logic [XLEN-1:0] pc_e, pcplus4_e, rd1_e, rd2_e, immext_e;
    logic [4:0]      rs1_e, rs2_e, rd_e;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0]     bubble_cnt;
`endif

    int     vectors;
    int     miscompares;
    stage_t drv;
    stage_t expStage;
    longint expCnt;

    id_ex_reg #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall_e   (stall_e),
        .flush_e   (flush_e),
        .valid_d   (valid_d),
        .ctrl_d    (ctrl_d),
        .pc_d      (pc_d),
        .pcplus4_d (pcplus4_d),
        .rd1_d     (rd1_d),
        .rd2_d     (rd2_d),
        .immext_d  (immext_d),
        .rs1_d     (rs1_d),
        .rs2_d     (rs2_d),
        .rd_d      (rd_d),
        .valid_e   (valid_e),
        .ctrl_e    (ctrl_e),
        .pc_e      (pc_e),
        .pcplus4_e (pcplus4_e),
        .rd1_e     (rd1_e),
        .rd2_e     (rd2_e),
        .immext_e  (immext_e),
        .rs1_e     (rs1_e),
        .rs2_e     (rs2_e),
        .rd_e      (rd_e)
`ifdef ID_EX_BUBBLE_CNT_EN
        ,
        .bubble_cnt(bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // An empty EX slot: not valid, NOP controls, every other field zero.
    function automatic stage_t bubble();
        stage_t s;
        s.valid   = 1'b0;
        s.ctrl    = CTRL_NOP;
        s.pc      = '0;
        s.pcplus4 = '0;
        s.rd1     = '0;
        s.rd2     = '0;
        s.immext  = '0;
        s.rs1     = '0;
        s.rs2     = '0;
        s.rd      = '0;
        return s;
    endfunction

    task automatic randomizeDrv();
        logic [$bits(ctrl_t)-1:0] c;
        c           = $bits(ctrl_t)'($urandom);
        drv.ctrl    = c;
        drv.valid   = ($urandom_range(0, 3) != 0);
        drv.pc      = $urandom;
        drv.pcplus4 = drv.pc + 32'd4;
        drv.rd1     = $urandom;
        drv.rd2     = $urandom;
        drv.immext  = $urandom;
        drv.rs1     = 5'($urandom);
        drv.rs2     = 5'($urandom);
        drv.rd      = 5'($urandom);
    endtask

    task automatic checkField(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkField({tag, ".valid_e"},   64'(valid_e),   64'(expStage.valid));
        checkField({tag, ".ctrl_e"},    64'(ctrl_e),    64'(expStage.ctrl));
        checkField({tag, ".pc_e"},      64'(pc_e),      64'(expStage.pc));
        checkField({tag, ".pcplus4_e"}, 64'(pcplus4_e), 64'(expStage.pcplus4));
        checkField({tag, ".rd1_e"},     64'(rd1_e),     64'(expStage.rd1));
        checkField({tag, ".rd2_e"},     64'(rd2_e),     64'(expStage.rd2));
        checkField({tag, ".immext_e"},  64'(immext_e),  64'(expStage.immext));
        checkField({tag, ".rs1_e"},     64'(rs1_e),     64'(expStage.rs1));
        checkField({tag, ".rs2_e"},     64'(rs2_e),     64'(expStage.rs2));
        checkField({tag, ".rd_e"},      64'(rd_e),      64'(expStage.rd));
`ifdef ID_EX_BUBBLE_CNT_EN
        checkField({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(expCnt));
`endif
    endtask

    // Drive the decode-side values in drv, advance one edge, update the model, check.
    task automatic applyStimulus(input string tag, input logic flush, input logic stall);
        flush_e   = flush;
        stall_e   = stall;
        valid_d   = drv.valid;
        ctrl_d    = drv.ctrl;
        pc_d      = drv.pc;
        pcplus4_d = drv.pcplus4;
        rd1_d     = drv.rd1;
        rd2_d     = drv.rd2;
        immext_d  = drv.immext;
        rs1_d     = drv.rs1;
        rs2_d     = drv.rs2;
        rd_d      = drv.rd;
        if (flush || (!stall && !drv.valid)) begin
            expStage = bubble();
            expCnt   = (expCnt + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : expCnt + 1;
        end else if (!stall) begin
            expStage       = drv;
            expStage.valid = 1'b1;
        end
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic assertReset(input string tag);
        @(negedge clk);
        rst_n    = 1'b0;
        #1;
        expStage = bubble();
        expCnt   = 0;
        checkOutput(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        expCnt      = 0;
        rst_n       = 1'b0;
        drv         = bubble();
        stall_e     = 1'b0;
        flush_e     = 1'b0;
        valid_d     = 1'b0;
        ctrl_d      = CTRL_NOP;
        pc_d        = '0;
        pcplus4_d   = '0;
        rd1_d       = '0;
        rd2_d       = '0;
        immext_d    = '0;
        rs1_d       = '0;
        rs2_d       = '0;
        rd_d        = '0;
        expStage    = bubble();
        #2;
        checkOutput("reset_initial");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed load with a negative immediate.
        randomizeDrv();
        drv.valid  = 1'b1;
        drv.pc     = 32'h0000_0100;
        drv.pcplus4 = 32'h0000_0104;
        drv.immext = 32'hFFFF_FFF8;
        drv.rd     = 5'd5;
        applyStimulus("load", 1'b0, 1'b0);

        // Stall three edges while decode keeps changing, then release.
        for (int i = 0; i < 3; i++) begin
            randomizeDrv();
            applyStimulus("stall_hold", 1'b0, 1'b1);
        end
        randomizeDrv();
        drv.valid = 1'b1;
        applyStimulus("stall_release", 1'b0, 1'b0);

        // Flush has priority over stall even with a register-writing op.
        randomizeDrv();
        drv.valid         = 1'b1;
        drv.ctrl.regwrite = 1'b1;
        drv.rd            = 5'd7;
        applyStimulus("flush_beats_stall", 1'b1, 1'b1);

        // Empty decode slot carrying a store must not reach EX.
        randomizeDrv();
        drv.valid         = 1'b0;
        drv.ctrl.memwrite = 1'b1;
        applyStimulus("invalid_decode", 1'b0, 1'b0);

        // Empty decode slot while stalled is held, not bubbled.
        randomizeDrv();
        drv.valid = 1'b1;
        applyStimulus("load_before_stall", 1'b0, 1'b0);
        randomizeDrv();
        drv.valid = 1'b0;
        applyStimulus("stall_invalid", 1'b0, 1'b1);

        // Reset asserted in the middle of a stall and of a flush.
        stall_e = 1'b1;
        assertReset("reset_mid_stall");
        randomizeDrv();
        drv.valid = 1'b1;
        applyStimulus("load_after_reset", 1'b0, 1'b0);
        flush_e = 1'b1;
        assertReset("reset_mid_flush");

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            randomizeDrv();
            applyStimulus("random", ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
        end

`ifdef ID_EX_BUBBLE_CNT_EN
        // Counter saturation from just below the top.
        @(negedge clk);
        force dut.bubble_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.bubble_cnt;
        expCnt = 64'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            randomizeDrv();
            applyStimulus("saturate", 1'b1, 1'b0);
        end
        randomizeDrv();
        applyStimulus("saturate_stall", 1'b0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
